// File: rtl/cordic_host_if_pkg.sv
// Shared definitions for the cordic host interface: word layout and function codes.
package cordic_host_if_pkg;

    localparam int TOTAL_WIDTH = 49;

    // Field positions inside an operation/result word
    localparam int FUNC_BIT = 48;
    localparam int X_MSB    = 47;
    localparam int X_LSB    = 32;
    localparam int Y_MSB    = 31;
    localparam int Y_LSB    = 16;
    localparam int Z_MSB    = 15;
    localparam int Z_LSB    = 0;

    typedef enum logic {
        FUNC_ROTATE = 1'b0,
        FUNC_VECTOR = 1'b1
    } func_e;

    // Assemble an operation word from its fields
    function automatic logic [TOTAL_WIDTH-1:0] pack_op(
        input func_e       func,
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [15:0] z
    );
        return {func, x, y, z};
    endfunction

endpackage

// File: rtl/cordic_rsp_fifo.sv
// First-word-fall-through result FIFO; full/empty derived from an occupancy counter.
module cordic_rsp_fifo
    import cordic_host_if_pkg::*;
#(
    parameter int WIDTH = TOTAL_WIDTH,
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_do_wr;
    logic w_do_rd;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_do_wr = i_wr && !w_full;
    assign w_do_rd = i_rd && !w_empty;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; memory contents are deliberately not reset
    always_ff @(posedge i_clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_vld   = !w_empty;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    a_no_write_when_full: assert property (@(posedge i_clk) disable iff (i_rst) !(i_wr && w_full));

endmodule

// File: rtl/cordic_host_if.sv
// Host-side initiator for the cordic: issues requests, tracks credits, buffers results in order.
module cordic_host_if
    import cordic_host_if_pkg::*;
#(
    parameter int TOTAL_WIDTH = cordic_host_if_pkg::TOTAL_WIDTH,
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   s_vld,
    output logic                   s_rdy,
    input  logic [TOTAL_WIDTH-1:0] s_data,
    output logic                   c_vld,
    output logic [TOTAL_WIDTH-1:0] c_data,
    input  logic                   c_rsp_vld,
    input  logic [TOTAL_WIDTH-1:0] c_rsp_data,
    output logic                   m_vld,
    input  logic                   m_rdy,
    output logic [TOTAL_WIDTH-1:0] m_data,
    output logic [CNT_W-1:0]       o_inflight,
    output logic                   o_err_unexp,
    input  logic                   i_clr_err
);

    logic [CNT_W-1:0]       r_credits;
    logic [CNT_W-1:0]       r_inflight;
    logic                   r_c_vld;
    logic [TOTAL_WIDTH-1:0] r_c_data;
    logic                   r_err_unexp;

    logic                   w_accept;
    logic                   w_pop;
    logic                   w_rsp_exp;
    logic                   w_rsp_unexp;
    logic                   w_fifo_vld;
    logic [TOTAL_WIDTH-1:0] w_fifo_data;
    logic [CNT_W-1:0]       w_fifo_count;

    // Ready depends on registered credits only, so s_vld never feeds back into s_rdy
    assign s_rdy       = (r_credits != '0);
    assign w_accept    = s_vld && s_rdy;
    assign w_pop       = w_fifo_vld && m_rdy;
    assign w_rsp_exp   = c_rsp_vld && (r_inflight != '0);
    assign w_rsp_unexp = c_rsp_vld && (r_inflight == '0);

    // Credit counter: one FIFO slot reserved per accepted operation, returned on pop
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_credits <= CNT_W'(DEPTH);
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_credits <= r_credits - 1'b1;
                2'b01:   r_credits <= r_credits + 1'b1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    // In-flight counter: operations issued to the cordic and not yet returned
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_accept, w_rsp_exp})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Issue register: one-cycle pulse per accept, data held between pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_c_vld  <= 1'b0;
            r_c_data <= '0;
        end else begin
            r_c_vld <= w_accept;
            if (w_accept) r_c_data <= s_data;
        end
    end

    // Sticky unexpected-response flag; a new event outranks a same-cycle clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_unexp <= 1'b0;
        end else if (w_rsp_unexp) begin
            r_err_unexp <= 1'b1;
        end else if (i_clr_err) begin
            r_err_unexp <= 1'b0;
        end
    end

    cordic_rsp_fifo #(
        .WIDTH (TOTAL_WIDTH),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wr    (w_rsp_exp),
        .i_wdata (c_rsp_data),
        .i_rd    (w_pop),
        .o_vld   (w_fifo_vld),
        .o_rdata (w_fifo_data),
        .o_count (w_fifo_count)
    );

    assign c_vld       = r_c_vld;
    assign c_data      = r_c_data;
    assign m_vld       = w_fifo_vld;
    assign m_data      = w_fifo_data;
    assign o_inflight  = r_inflight;
    assign o_err_unexp = r_err_unexp;

    // Every slot is either a free credit, an operation in flight, or a buffered result
    a_credit_conservation: assert property (@(posedge i_clk) disable iff (i_rst)
        (int'(r_credits) + int'(r_inflight) + int'(w_fifo_count)) == DEPTH);

endmodule

// File: tb/tb_cordic_host_if.sv
// Self-checking bench for cordic_host_if with a 20-cycle in-order cordic model.
module tb_cordic_host_if;
    import cordic_host_if_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LAT   = 20;

    logic                   i_clk = 1'b0;
    logic                   i_rst;
    logic                   s_vld;
    logic                   s_rdy;
    logic [TOTAL_WIDTH-1:0] s_data;
    logic                   c_vld;
    logic [TOTAL_WIDTH-1:0] c_data;
    logic                   c_rsp_vld;
    logic [TOTAL_WIDTH-1:0] c_rsp_data;
    logic                   m_vld;
    logic                   m_rdy;
    logic [TOTAL_WIDTH-1:0] m_data;
    logic [CNT_W-1:0]       o_inflight;
    logic                   o_err_unexp;
    logic                   i_clr_err;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    cordic_host_if #(
        .TOTAL_WIDTH (TOTAL_WIDTH),
        .DEPTH       (DEPTH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .s_vld       (s_vld),
        .s_rdy       (s_rdy),
        .s_data      (s_data),
        .c_vld       (c_vld),
        .c_data      (c_data),
        .c_rsp_vld   (c_rsp_vld),
        .c_rsp_data  (c_rsp_data),
        .m_vld       (m_vld),
        .m_rdy       (m_rdy),
        .m_data      (m_data),
        .o_inflight  (o_inflight),
        .o_err_unexp (o_err_unexp),
        .i_clr_err   (i_clr_err)
    );

    // Cordic stand-in: known answer for the reference vector, otherwise X field scrambled
    function automatic logic [TOTAL_WIDTH-1:0] cordic_fn(input logic [TOTAL_WIDTH-1:0] d);
        if (d == 49'h0_4000_0000_2000) return 49'h0_26DD_1B74_0000;
        return d ^ 49'h0_5A5A_0000_0000;
    endfunction

    function automatic logic [TOTAL_WIDTH-1:0] mk(input int z);
        return pack_op(FUNC_ROTATE, 16'h1000, 16'h0000, 16'(z));
    endfunction

    logic [LAT-1:0]         r_pv;
    logic [TOTAL_WIDTH-1:0] r_pd [LAT];
    logic                   inj_vld;
    logic [TOTAL_WIDTH-1:0] inj_data;

    // Fixed-latency cordic pipeline sharing the design reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pv <= '0;
        end else begin
            r_pv     <= {r_pv[LAT-2:0], c_vld};
            r_pd[0]  <= cordic_fn(c_data);
            for (int i = 1; i < LAT; i++) r_pd[i] <= r_pd[i-1];
        end
    end

    assign c_rsp_vld  = r_pv[LAT-1] | inj_vld;
    assign c_rsp_data = inj_vld ? inj_data : r_pd[LAT-1];

    int                     n_cvld = 0;
    logic [TOTAL_WIDTH-1:0] popped [$];

    // Monitor: count issue pulses and log every popped result word
    always @(posedge i_clk) begin
        if (c_vld) n_cvld++;
        if (m_vld && m_rdy) popped.push_back(m_data);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        logic rsp;
        logic clr;
        logic exp_err;
        logic exp_mvld;
    } err_vec_t;

    err_vec_t err_tab [7];

    initial begin
        int n_acc;
        int n;
        int base;
        int z;
        int cyc;
        int got;
        logic acc_now;

        err_tab[0] = '{rsp: 1'b1, clr: 1'b0, exp_err: 1'b1, exp_mvld: 1'b0};
        err_tab[1] = '{rsp: 1'b0, clr: 1'b0, exp_err: 1'b1, exp_mvld: 1'b0};
        err_tab[2] = '{rsp: 1'b0, clr: 1'b1, exp_err: 1'b0, exp_mvld: 1'b0};
        err_tab[3] = '{rsp: 1'b0, clr: 1'b0, exp_err: 1'b0, exp_mvld: 1'b0};
        err_tab[4] = '{rsp: 1'b1, clr: 1'b0, exp_err: 1'b1, exp_mvld: 1'b0};
        err_tab[5] = '{rsp: 1'b1, clr: 1'b1, exp_err: 1'b1, exp_mvld: 1'b0};
        err_tab[6] = '{rsp: 1'b0, clr: 1'b1, exp_err: 1'b0, exp_mvld: 1'b0};

        i_rst = 1'b1; s_vld = 1'b0; s_data = '0; m_rdy = 1'b0;
        i_clr_err = 1'b0; inj_vld = 1'b0; inj_data = '0;
        ticks(3);
        chk("rst_c_vld", c_vld, 0);
        chk("rst_c_data", c_data, 0);
        chk("rst_inflight", o_inflight, 0);
        chk("rst_err", o_err_unexp, 0);
        chk("rst_m_vld", m_vld, 0);
        chk("rst_s_rdy", s_rdy, 1);
        i_rst = 1'b0;
        tick();

        // Single operation through the 20-cycle model
        s_vld = 1'b1; s_data = 49'h0_4000_0000_2000;
        tick();
        s_vld = 1'b0;
        chk("single_c_vld", c_vld, 1);
        chk("single_c_data", c_data, 49'h0_4000_0000_2000);
        chk("single_inflight_1", o_inflight, 1);
        n = 0;
        while (!c_rsp_vld && n < 60) begin tick(); n++; end
        chk("single_rsp_latency", n, LAT);
        chk("single_m_vld_before", m_vld, 0);
        tick();
        chk("single_m_vld", m_vld, 1);
        chk("single_m_data", m_data, 49'h0_26DD_1B74_0000);
        chk("single_inflight_0", o_inflight, 0);
        m_rdy = 1'b1; tick(); m_rdy = 1'b0;
        chk("single_popped_empty", m_vld, 0);

        // Credit exhaustion with the result port stalled
        base = popped.size();
        n = n_cvld;
        n_acc = 0;
        s_vld = 1'b1; s_data = mk(100);
        for (int i = 0; i < 12; i++) begin
            acc_now = s_rdy;
            tick();
            if (acc_now) begin n_acc++; s_data = mk(100 + n_acc); end
        end
        s_vld = 1'b0;
        chk("exh_accepts", n_acc, 8);
        chk("exh_s_rdy_low", s_rdy, 0);
        ticks(LAT + 5);
        chk("exh_c_vld_pulses", n_cvld - n, 8);
        chk("exh_inflight_0", o_inflight, 0);
        chk("exh_m_vld", m_vld, 1);
        chk("exh_head", m_data, cordic_fn(mk(100)));
        m_rdy = 1'b1; tick(); m_rdy = 1'b0;
        chk("exh_s_rdy_after_pop", s_rdy, 1);
        n_acc = 0;
        s_vld = 1'b1; s_data = mk(108);
        for (int i = 0; i < 3; i++) begin
            acc_now = s_rdy;
            tick();
            if (acc_now) n_acc++;
        end
        s_vld = 1'b0;
        chk("exh_one_more_accept", n_acc, 1);
        m_rdy = 1'b1; ticks(LAT + 10); m_rdy = 1'b0;
        chk("exh_pop_count", popped.size() - base, 9);
        for (int k = 0; k < 9 && base + k < popped.size(); k++)
            chk($sformatf("exh_order_%0d", k), popped[base + k], cordic_fn(mk(100 + k)));

        // Credits at 1: accept and pop on the same edge leave one credit
        s_vld = 1'b1;
        for (int k = 0; k < 7; k++) begin s_data = mk(200 + k); tick(); end
        s_vld = 1'b0;
        ticks(LAT + 5);
        chk("c1_buffered_head", m_data, cordic_fn(mk(200)));
        s_vld = 1'b1; s_data = mk(207); m_rdy = 1'b1;
        tick();
        m_rdy = 1'b0;
        chk("c1_s_rdy_kept", s_rdy, 1);
        s_data = mk(208);
        tick();
        s_vld = 1'b0;
        chk("c1_s_rdy_exhausted", s_rdy, 0);
        m_rdy = 1'b1; tick(); m_rdy = 1'b0;
        n = 0;
        while (!c_rsp_vld && n < 60) begin tick(); n++; end
        chk("c1_rsp_seen", c_rsp_vld, 1);
        chk("c1_inflight_before", o_inflight, 2);
        s_vld = 1'b1; s_data = mk(209);
        acc_now = s_rdy;
        tick();
        s_vld = 1'b0;
        chk("c1_accept_with_rsp", acc_now, 1);
        chk("c1_inflight_same", o_inflight, 2);
        m_rdy = 1'b1; ticks(LAT + 10); m_rdy = 1'b0;
        chk("c1_drained_inflight", o_inflight, 0);
        chk("c1_drained_m_vld", m_vld, 0);

        // Unexpected responses and sticky error flag
        for (int r = 0; r < 7; r++) begin
            inj_vld   = err_tab[r].rsp;
            inj_data  = {$urandom(), $urandom()};
            i_clr_err = err_tab[r].clr;
            tick();
            inj_vld = 1'b0; i_clr_err = 1'b0;
            chk($sformatf("err_row%0d_flag", r), o_err_unexp, err_tab[r].exp_err);
            chk($sformatf("err_row%0d_m_vld", r), m_vld, err_tab[r].exp_mvld);
            chk($sformatf("err_row%0d_inflight", r), o_inflight, 0);
        end

        // Ordering across several pointer wraps with random handshakes
        base = popped.size();
        z = 0;
        cyc = 0;
        while ((popped.size() - base) < 40 && cyc < 4000) begin
            s_vld  = (z < 40) && ($urandom_range(0, 1) == 1);
            s_data = mk(z);
            m_rdy  = ($urandom_range(0, 2) != 0);
            acc_now = s_vld && s_rdy;
            tick();
            if (acc_now) z++;
            cyc++;
        end
        s_vld = 1'b0;
        m_rdy = 1'b1; ticks(LAT + 10); m_rdy = 1'b0;
        got = popped.size() - base;
        chk("ord_count", got, 40);
        for (int k = 0; k < 40 && k < got; k++)
            chk($sformatf("ord_%0d", k), popped[base + k], cordic_fn(mk(k)));

        // Reset with operations both in flight and buffered
        s_vld = 1'b1;
        for (int k = 0; k < 2; k++) begin s_data = mk(300 + k); tick(); end
        s_vld = 1'b0;
        ticks(LAT + 5);
        s_vld = 1'b1;
        for (int k = 0; k < 5; k++) begin s_data = mk(302 + k); tick(); end
        s_vld = 1'b0;
        ticks(3);
        chk("rmid_inflight_5", o_inflight, 5);
        chk("rmid_m_vld_buf", m_vld, 1);
        i_rst = 1'b1;
        #1;
        chk("rmid_m_vld", m_vld, 0);
        chk("rmid_c_vld", c_vld, 0);
        chk("rmid_inflight", o_inflight, 0);
        chk("rmid_err", o_err_unexp, 0);
        tick();
        i_rst = 1'b0;
        tick();
        chk("rmid_s_rdy", s_rdy, 1);
        n_acc = 0;
        s_vld = 1'b1; s_data = mk(400);
        for (int i = 0; i < 10; i++) begin
            acc_now = s_rdy;
            tick();
            if (acc_now) begin n_acc++; s_data = mk(400 + n_acc); end
        end
        s_vld = 1'b0;
        chk("rmid_full_credits", n_acc, 8);
        ticks(LAT + 5);
        chk("rmid_inflight_after", o_inflight, 0);
        chk("rmid_no_stale_err", o_err_unexp, 0);
        chk("rmid_head_fresh", m_data, cordic_fn(mk(400)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a loop above fails to terminate
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
